slow_clock_monitor: RTL and testbench

//   Receive-side counterpart to the clock divider. Takes a slow, free-running square

---
 rtl/slow_clock_monitor.sv | 128 ++++++++++++
 tb/tb_slow_clock_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_monitor.sv
// Synchronizes a slow asynchronous square wave into the fast clock domain. Emits one tick per
// rising edge, measures the rise-to-rise period in fast cycles and flags loss of the slow clock.
module slow_clock_monitor #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PERIOD_WIDTH = 32,
    parameter int unsigned TIMEOUT      = 50000000,
    parameter int unsigned EDGE_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    slowClock,
    output logic                    tick,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    periodValid,
    output logic                    timeout,
    output logic [EDGE_WIDTH-1:0]   edgeCount
);

    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StLost
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_out;
    logic                    history_q;
    logic                    rise_q;
    logic                    tick_q;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    cnt_at_limit;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    valid_q, valid_d;
    logic                    timeout_q, timeout_d;
    logic [EDGE_WIDTH-1:0]   edge_q, edge_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The detected edge is registered once more, so every consumer below sees the rise on the
    // same posedge that tick goes high: SYNC_STAGES+1 cycles after slowClock was sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            history_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], slowClock};
            history_q <= sync_out;
            rise_q    <= sync_out & ~history_q;
        end
    end

    // Counter restarts at 1 on each edge so it equals the tick spacing at the next edge.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_q) begin
            cnt_d = PERIOD_WIDTH'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
    end

    assign cnt_at_limit = (cnt_q == PERIOD_WIDTH'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StSearch: begin
                if (rise_q) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                // An edge arriving on the timeout cycle still counts as a valid measurement.
                if (rise_q) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                end else if (cnt_at_limit) begin
                    state_d   = StLost;
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            StLost: begin
                if (rise_q) begin
                    state_d   = StMeasure;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    assign edge_d = rise_q ? edge_q + EDGE_WIDTH'(1) : edge_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StSearch;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            edge_q    <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= rise_q;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            edge_q    <= edge_d;
        end
    end

    assign tick        = tick_q;
    assign period      = period_q;
    assign periodValid = valid_q;
    assign timeout     = timeout_q;
    assign edgeCount   = edge_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor: directed timing scenarios plus randomized slow-clock waveforms
// checked cycle by cycle against an event-level model (edge times, gaps and timeouts).
module tb_slow_clock_monitor;

    localparam int unsigned TO  = 20;
    localparam int unsigned SS  = 2;
    localparam int unsigned PW  = 32;
    localparam int unsigned EW  = 4;
    localparam int          LAT = SS + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          slowClock = 1'b0;
    logic          tick;
    logic [PW-1:0] period;
    logic          periodValid;
    logic          timeout;
    logic [EW-1:0] edgeCount;

    always #5 clock = ~clock;

    slow_clock_monitor #(
        .SYNC_STAGES (SS),
        .PERIOD_WIDTH(PW),
        .TIMEOUT     (TO),
        .EDGE_WIDTH  (EW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .slowClock  (slowClock),
        .tick       (tick),
        .period     (period),
        .periodValid(periodValid),
        .timeout    (timeout),
        .edgeCount  (edgeCount)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: edge times and gaps, not registers.
    logic          m_prev = 1'b0;
    int            pend[$];
    int            m_last = -1;
    bit            m_lost = 1'b0;
    logic          m_tick = 1'b0;
    logic [PW-1:0] m_period = '0;
    logic          m_valid = 1'b0;
    logic          m_timeout = 1'b0;
    logic [EW-1:0] m_edges = '0;

    task automatic cycle(input logic s, input logic r);
        slowClock = s;
        reset     = r;
        @(posedge clock);
        cyc++;
        if (r) begin
            m_prev = 1'b0;
            pend.delete();
            m_last = -1;
            m_lost = 1'b0;
            m_tick = 1'b0;
            m_period = '0;
            m_valid = 1'b0;
            m_timeout = 1'b0;
            m_edges = '0;
        end else begin
            m_tick = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                m_tick = 1'b1;
            end
            if (m_tick) begin
                m_edges = m_edges + 1'b1;
                if (m_last >= 0 && !m_lost) begin
                    m_period = PW'(cyc - m_last);
                    m_valid  = 1'b1;
                end
                m_lost    = 1'b0;
                m_timeout = 1'b0;
                m_last    = cyc;
            end else if (m_last >= 0 && !m_lost && (cyc - m_last) == int'(TO)) begin
                m_lost    = 1'b1;
                m_timeout = 1'b1;
                m_valid   = 1'b0;
            end
            if (s && !m_prev) pend.push_back(cyc + LAT);
            m_prev = s;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(logic'(i % 2), 1'b1);
            n_cmp++;
            if (tick !== 1'b0 || period !== '0 || periodValid !== 1'b0 || timeout !== 1'b0 ||
                edgeCount !== '0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got t=%0b p=%0d v=%0b to=%0b e=%0d want all 0",
                         cyc, tick, period, periodValid, timeout, edgeCount);
            end
        end
        cycle(1'b1, 1'b0);
        n_cmp++;
        if (tick !== 1'b0 || period !== '0 || periodValid !== 1'b0 || timeout !== 1'b0 ||
            edgeCount !== '0) begin
            n_bad++;
            $display("FAIL reset_release cyc=%0d got t=%0b p=%0d v=%0b to=%0b e=%0d want all 0",
                     cyc, tick, period, periodValid, timeout, edgeCount);
        end
    endtask

    task automatic test_square10();
        int r0;
        cycle(1'b0, 1'b1);
        r0 = cyc + 1;
        for (int i = 0; i < 75; i++) begin
            cycle(logic'(i < 30 && (i % 10) < 5), 1'b0);
            n_cmp++;
            if (tick !== m_tick || period !== m_period || periodValid !== m_valid ||
                timeout !== m_timeout || edgeCount !== m_edges) begin
                n_bad++;
                $display("FAIL square10_model cyc=%0d got t=%0b p=%0d v=%0b to=%0b e=%0d want %0b %0d %0b %0b %0d",
                         cyc, tick, period, periodValid, timeout, edgeCount,
                         m_tick, m_period, m_valid, m_timeout, m_edges);
            end
            if (cyc == r0 + 3 || cyc == r0 + 13 || cyc == r0 + 23) begin
                n_cmp++;
                if (tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL square10_tick cyc=%0d got %0b want 1", cyc - r0, tick);
                end
            end
            if (cyc == r0 + 13) begin
                n_cmp++;
                if (period !== 10 || periodValid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL square10_period got p=%0d v=%0b want 10 1", period, periodValid);
                end
            end
            if (cyc == r0 + 23) begin
                n_cmp++;
                if (edgeCount !== 3) begin
                    n_bad++;
                    $display("FAIL square10_edges got %0d want 3", edgeCount);
                end
            end
            if (cyc == r0 + 42) begin
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_bad++;
                    $display("FAIL lost_early got timeout=%0b want 0", timeout);
                end
            end
            if (cyc == r0 + 43) begin
                n_cmp++;
                if (timeout !== 1'b1 || periodValid !== 1'b0 || period !== 10) begin
                    n_bad++;
                    $display("FAIL lost_enter got to=%0b v=%0b p=%0d want 1 0 10",
                             timeout, periodValid, period);
                end
            end
        end
    endtask

    task automatic test_resume();
        int t;
        t = cyc + 1 + LAT;
        for (int i = 0; i < 30; i++) begin
            cycle(logic'(i < 18 && (i % 12) < 6), 1'b0);
            if (cyc == t - 1) begin
                n_cmp++;
                if (timeout !== 1'b1) begin
                    n_bad++;
                    $display("FAIL resume_prelost got timeout=%0b want 1", timeout);
                end
            end
            if (cyc == t) begin
                n_cmp++;
                if (timeout !== 1'b0 || periodValid !== 1'b0 || period !== 10 || tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL resume_first got to=%0b v=%0b p=%0d t=%0b want 0 0 10 1",
                             timeout, periodValid, period, tick);
                end
            end
            if (cyc == t + 12) begin
                n_cmp++;
                if (period !== 12 || periodValid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL resume_publish got p=%0d v=%0b want 12 1", period, periodValid);
                end
            end
        end
    endtask

    task automatic test_exact_timeout();
        int r;
        logic saw_to;
        saw_to = 1'b0;
        cycle(1'b0, 1'b1);
        r = cyc + 1;
        for (int i = 0; i < 70; i++) begin
            cycle(logic'(i < 41 && (i % 20) < 10), 1'b0);
            if (cyc <= r + 43) saw_to = saw_to | timeout;
            if (cyc == r + 23 || cyc == r + 43) begin
                n_cmp++;
                if (period !== 20 || periodValid !== 1'b1 || tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL exact_timeout_period cyc=%0d got p=%0d v=%0b t=%0b want 20 1 1",
                             cyc - r, period, periodValid, tick);
                end
            end
        end
        n_cmp++;
        if (saw_to !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_timeout_pulse got timeout seen=%0b want 0", saw_to);
        end
    endtask

    task automatic test_edge_wrap();
        int r;
        cycle(1'b0, 1'b1);
        r = cyc + 1;
        for (int i = 0; i < 72; i++) begin
            cycle(logic'(i < 68 && (i % 4) < 2), 1'b0);
            n_cmp++;
            if (tick !== m_tick || period !== m_period || periodValid !== m_valid ||
                timeout !== m_timeout || edgeCount !== m_edges) begin
                n_bad++;
                $display("FAIL wrap_model cyc=%0d got t=%0b p=%0d v=%0b to=%0b e=%0d want %0b %0d %0b %0b %0d",
                         cyc, tick, period, periodValid, timeout, edgeCount,
                         m_tick, m_period, m_valid, m_timeout, m_edges);
            end
            if (cyc == r + 59 || cyc == r + 63 || cyc == r + 67) begin
                n_cmp++;
                if (edgeCount !== EW'((((cyc - r - 3) / 4) + 1) % 16)) begin
                    n_bad++;
                    $display("FAIL wrap_edges cyc=%0d got %0d want %0d", cyc - r, edgeCount,
                             (((cyc - r - 3) / 4) + 1) % 16);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        n_cmp++;
        if (tick !== 1'b0 || period !== '0 || periodValid !== 1'b0 || timeout !== 1'b0 ||
            edgeCount !== '0) begin
            n_bad++;
            $display("FAIL reset_mid got t=%0b p=%0d v=%0b to=%0b e=%0d want all 0",
                     tick, period, periodValid, timeout, edgeCount);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
            n_cmp++;
            if (tick !== 1'b0 || period !== '0 || periodValid !== 1'b0 || edgeCount !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_flush got t=%0b p=%0d v=%0b e=%0d want all 0",
                         tick, period, periodValid, edgeCount);
            end
        end
    endtask

    task automatic test_random();
        logic lvl;
        int   remaining;
        logic r;
        lvl = 1'b0;
        remaining = 0;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (remaining == 0) begin
                lvl = ~lvl;
                remaining = ($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 40))
                                                        : int'($urandom_range(1, 12));
            end
            r = logic'($urandom_range(0, 299) == 0);
            cycle(lvl, r);
            remaining--;
            n_cmp++;
            if (tick !== m_tick || period !== m_period || periodValid !== m_valid ||
                timeout !== m_timeout || edgeCount !== m_edges) begin
                n_bad++;
                $display("FAIL random cyc=%0d got t=%0b p=%0d v=%0b to=%0b e=%0d want %0b %0d %0b %0b %0d",
                         cyc, tick, period, periodValid, timeout, edgeCount,
                         m_tick, m_period, m_valid, m_timeout, m_edges);
            end
        end
    endtask

    initial begin
        test_reset();
        test_square10();
        test_resume();
        test_exact_timeout();
        test_edge_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
